// File: rtl/fire_arbiter.sv
// Round-robin bullet-slot arbiter with per-tank reload cooldown and slot lifetime, advanced by the game tick.
// Optional build macro FIRE_PLAYER_PRIORITY_EN: requester 0 wins whenever eligible.
module fire_arbiter #(
  parameter int NREQ     = 4,
  parameter int NSLOT    = 2,
  parameter int COOLDOWN = 30,
  parameter int LIFE     = 120,
  parameter int OW       = $clog2(NREQ),
  parameter int SW       = $clog2(NSLOT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NREQ-1:0]     req,
  input  logic [NSLOT-1:0]    hit,
  output logic [NREQ-1:0]     grant,
  output logic [SW-1:0]       grant_slot,
  output logic [NSLOT-1:0]    slot_active,
  output logic [NSLOT*OW-1:0] slot_owner,
  output logic                busy
);

  localparam int unsigned NREQ_U  = NREQ;
  localparam int unsigned NSLOT_U = NSLOT;
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam int LW = $clog2(LIFE + 1);
  // Loaded with COOLDOWN+1: S_AGE decrements before S_ARB checks for zero,
  // so a requester granted on tick n is eligible again on tick n+COOLDOWN+1.
  localparam logic [CW-1:0] CD_LOAD   = CW'(COOLDOWN + 1);
  localparam logic [LW-1:0] LIFE_LOAD = LW'(LIFE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_AGE   = 2'd1;
  localparam logic [1:0] S_ARB   = 2'd2;
  localparam logic [1:0] S_GRANT = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [OW-1:0]               rr_q, rr_d;
  logic [OW-1:0]               win_q, win_d;
  logic [NREQ-1:0][CW-1:0]     cd_q, cd_d;
  logic [NSLOT-1:0][LW-1:0]    life_q, life_d;
  logic [NSLOT-1:0]            act_q, act_d;
  logic [NSLOT-1:0][OW-1:0]    own_q, own_d;
  logic [NREQ-1:0]             grant_q, grant_d;
  logic [SW-1:0]               gslot_q, gslot_d;
  logic                        busy_q;
  logic [NREQ-1:0]             elig;
  logic [OW:0]                 pick;
  logic [SW:0]                 fpick;
  logic [OW-1:0]               nxt;

  function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] e, input logic [OW-1:0] ptr);
    logic [OW:0]   res;
    logic [OW-1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      idx = OW'((32'(ptr) + i) % NREQ_U);
      if (!res[OW] && e[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [SW:0] free_pick(input logic [NSLOT-1:0] act);
    logic [SW:0] res;
    res = '0;
    for (int unsigned k = 0; k < NSLOT_U; k++) begin
      if (!res[SW] && !act[k]) res = {1'b1, SW'(k)};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    cd_d    = cd_q;
    life_d  = life_q;
    act_d   = act_q;
    own_d   = own_q;
    grant_d = '0;
    gslot_d = '0;
    elig    = '0;
    for (int unsigned r = 0; r < NREQ_U; r++) begin
      elig[r] = req[r] && (cd_q[r] == '0);
    end
`ifdef FIRE_PLAYER_PRIORITY_EN
    pick = elig[0] ? {1'b1, OW'(0)} : rr_pick(elig & ~NREQ'(1), rr_q);
`else
    pick = rr_pick(elig, rr_q);
`endif
    fpick = free_pick(act_q);
    nxt   = (win_q == OW'(NREQ - 1)) ? OW'(0) : win_q + 1'b1;

    case (state_q)
      S_IDLE: if (tick) state_d = S_AGE;
      S_AGE: begin
        for (int unsigned r = 0; r < NREQ_U; r++) begin
          if (cd_q[r] != '0) cd_d[r] = cd_q[r] - 1'b1;
        end
        for (int unsigned k = 0; k < NSLOT_U; k++) begin
          if (act_q[k]) begin
            life_d[k] = life_q[k] - 1'b1;
            if (life_q[k] == LW'(1)) act_d[k] = 1'b0;
          end
        end
        state_d = S_ARB;
      end
      S_ARB: begin
        if (pick[OW] && fpick[SW]) begin
          win_d   = pick[OW-1:0];
          gslot_d = fpick[SW-1:0];
          grant_d = NREQ'(1) << pick[OW-1:0];
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        act_d[gslot_q]  = 1'b1;
        own_d[gslot_q]  = win_q;
        life_d[gslot_q] = LIFE_LOAD;
        cd_d[win_q]     = CD_LOAD;
`ifdef FIRE_PLAYER_PRIORITY_EN
        if (win_q != '0) rr_d = nxt;
`else
        rr_d = nxt;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Hits only affect slots already in flight, so a slot being granted this cycle is untouched.
    for (int unsigned k = 0; k < NSLOT_U; k++) begin
      if (hit[k] && act_q[k]) begin
        act_d[k]  = 1'b0;
        life_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      cd_q    <= '0;
      life_q  <= '0;
      act_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      gslot_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cd_q    <= cd_d;
      life_q  <= life_d;
      act_q   <= act_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      gslot_q <= gslot_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign grant       = grant_q;
  assign grant_slot  = gslot_q;
  assign slot_active = act_q;
  assign slot_owner  = own_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fire_arbiter.sv
// Scoreboard bench for fire_arbiter: instance A uses default parameters, instance B uses COOLDOWN=2, LIFE=3.
module tb_fire_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, sel;
  logic [3:0] req;
  logic [1:0] hit;
  logic [3:0] req_a, req_b, grant_a, grant_b, own_a, own_b;
  logic [1:0] hit_a, hit_b, act_a, act_b;
  logic       gslot_a, gslot_b, busy_a, busy_b;
  logic [3:0] grant_w, own_w;
  logic [1:0] act_w;
  logic       gslot_w, busy_w;

  assign req_a   = sel ? 4'b0 : req;
  assign req_b   = sel ? req : 4'b0;
  assign hit_a   = sel ? 2'b0 : hit;
  assign hit_b   = sel ? hit : 2'b0;
  assign grant_w = sel ? grant_b : grant_a;
  assign gslot_w = sel ? gslot_b : gslot_a;
  assign act_w   = sel ? act_b : act_a;
  assign own_w   = sel ? own_b : own_a;
  assign busy_w  = sel ? busy_b : busy_a;

  fire_arbiter u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .req(req_a), .hit(hit_a),
    .grant(grant_a), .grant_slot(gslot_a), .slot_active(act_a),
    .slot_owner(own_a), .busy(busy_a)
  );

  fire_arbiter #(.COOLDOWN(2), .LIFE(3)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .req(req_b), .hit(hit_b),
    .grant(grant_b), .grant_slot(gslot_b), .slot_active(act_b),
    .slot_owner(own_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [3:0] g;
    logic       s;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] g, input logic s);
    exp_t e;
    e.g = g;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b0; tick = 1'b0; req = '0; hit = '0;
    repeat (2) step();
    rst = 1'b1;
    sb.delete();
  endtask

  // One game tick: observes five cycles and compares the grant against the scoreboard head.
  task automatic do_tick(input logic [1:0] hage, input logic chk_age,
                         input logic [1:0] act_age, input logic xtick);
    exp_t       e;
    int         first_c, width;
    logic [3:0] gv;
    logic       sv;
    logic [5:0] bz;
    first_c = 0; width = 0; gv = '0; sv = 1'b0; bz = '0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) begin
        tick = 1'b1;
        step();
        hit = hage;
      end else begin
        step();
        hit = '0;
      end
      tick = xtick && (c <= 3);
      bz[c] = busy_w;
      if (grant_w !== 4'b0) begin
        if (width == 0) begin
          first_c = c; gv = grant_w; sv = gslot_w;
        end
        width++;
      end
      if (c == 2 && chk_age) begin
        n_cmp++;
        if (act_w !== act_age) begin
          n_bad++; $display("FAIL age_active: got %b want %b", act_w, act_age);
        end
      end
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got grant %b want an expectation entry", gv);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (gv !== e.g) begin
      n_bad++; $display("FAIL grant: got %b want %b", gv, e.g);
    end
    if (e.g != 4'b0) begin
      n_cmp++;
      if (first_c != 3) begin
        n_bad++; $display("FAIL grant_latency: got %0d want 3", first_c);
      end
      n_cmp++;
      if (width != 1) begin
        n_bad++; $display("FAIL grant_width: got %0d want 1", width);
      end
      n_cmp++;
      if (sv !== e.s) begin
        n_bad++; $display("FAIL grant_slot: got %b want %b", sv, e.s);
      end
      n_cmp++;
      if (bz[3] !== 1'b1 || bz[4] !== 1'b0) begin
        n_bad++; $display("FAIL busy_grant: got c3=%b c4=%b want 1 0", bz[3], bz[4]);
      end
    end else begin
      n_cmp++;
      if (bz[2] !== 1'b1 || bz[3] !== 1'b0) begin
        n_bad++; $display("FAIL busy_nogrant: got c2=%b c3=%b want 1 0", bz[2], bz[3]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      n_cmp++;
      if (grant_w !== 4'b0 || gslot_w !== 1'b0 || busy_w !== 1'b0) begin
        n_bad++; $display("FAIL reset_ctl[%0d]: got g=%b s=%b b=%b want 0", d, grant_w, gslot_w, busy_w);
      end
      n_cmp++;
      if (act_w !== 2'b0 || own_w !== 4'b0) begin
        n_bad++; $display("FAIL reset_slots[%0d]: got act=%b own=%b want 0", d, act_w, own_w);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_single_grant();
    sel = 1'b0;
    apply_reset();
    req = 4'b0001;
    push_exp(4'b0001, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    n_cmp++;
    if (act_w !== 2'b01 || own_w !== 4'b0000) begin
      n_bad++; $display("FAIL single_slot: got act=%b own=%b want 01 0000", act_w, own_w);
    end
  endtask

  task automatic test_pool_full_and_hit();
    sel = 1'b0;
    apply_reset();
    req = 4'b1111;
    push_exp(4'b0001, 1'b0);
    push_exp(4'b0010, 1'b1);
    push_exp(4'b0000, 1'b0);
    push_exp(4'b0000, 1'b0);
    repeat (4) do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    n_cmp++;
    if (act_w !== 2'b11 || own_w !== 4'b0100) begin
      n_bad++; $display("FAIL pool_full: got act=%b own=%b want 11 0100", act_w, own_w);
    end
    req = 4'b0000;
    hit = 2'b01;
    step();
    hit = 2'b00;
    n_cmp++;
    if (act_w !== 2'b10) begin
      n_bad++; $display("FAIL hit_free: got %b want 10", act_w);
    end
    hit = 2'b01;
    step();
    hit = 2'b00;
    n_cmp++;
    if (act_w !== 2'b10) begin
      n_bad++; $display("FAIL hit_inactive: got %b want 10", act_w);
    end
    req = 4'b0100;
    push_exp(4'b0100, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    n_cmp++;
    if (act_w !== 2'b11 || own_w !== 4'b0110) begin
      n_bad++; $display("FAIL regrant: got act=%b own=%b want 11 0110", act_w, own_w);
    end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] want;
    sel = 1'b0;
    apply_reset();
    req = 4'b0100;
    push_exp(4'b0100, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    req = 4'b0000;
    hit = 2'b01;
    step();
    hit = 2'b00;
`ifdef FIRE_PLAYER_PRIORITY_EN
    want = 4'b0001;
`else
    want = 4'b1000;
`endif
    req = 4'b1001;
    push_exp(want, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_tick_while_busy();
    int extra;
    sel = 1'b0;
    apply_reset();
    req = 4'b0001;
    push_exp(4'b0001, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b1);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (grant_w !== 4'b0) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL busy_tick_dropped: got %0d extra grant cycles want 0", extra);
    end
  endtask

  task automatic test_lifetime();
    sel = 1'b1;
    apply_reset();
    req = 4'b0001;
    push_exp(4'b0001, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    req = 4'b0000;
    repeat (3) push_exp(4'b0000, 1'b0);
    do_tick(2'b00, 1'b1, 2'b01, 1'b0);
    do_tick(2'b00, 1'b1, 2'b01, 1'b0);
    do_tick(2'b00, 1'b1, 2'b00, 1'b0);
    req = 4'b0010;
    push_exp(4'b0010, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    req = 4'b0000;
    repeat (3) push_exp(4'b0000, 1'b0);
    do_tick(2'b00, 1'b1, 2'b01, 1'b0);
    do_tick(2'b00, 1'b1, 2'b01, 1'b0);
    do_tick(2'b01, 1'b1, 2'b00, 1'b0);
    req = 4'b0100;
    push_exp(4'b0100, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    n_cmp++;
    if (act_w !== 2'b01 || own_w !== 4'b0010) begin
      n_bad++; $display("FAIL life_regrant: got act=%b own=%b want 01 0010", act_w, own_w);
    end
    sel = 1'b0;
  endtask

  task automatic test_cooldown();
    sel = 1'b1;
    apply_reset();
    req = 4'b0001;
    push_exp(4'b0001, 1'b0);
    push_exp(4'b0000, 1'b0);
    push_exp(4'b0000, 1'b0);
    push_exp(4'b0001, 1'b0);
    repeat (4) do_tick(2'b00, 1'b0, 2'b00, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_reset_in_arb();
    int seen;
    sel = 1'b0;
    apply_reset();
    req = 4'b0001;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_cmp++;
    if (grant_w !== 4'b0 || gslot_w !== 1'b0 || busy_w !== 1'b0 || act_w !== 2'b0 || own_w !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_in_arb: got g=%b s=%b b=%b act=%b own=%b want all 0",
               grant_w, gslot_w, busy_w, act_w, own_w);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (grant_w !== 4'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL abandoned_grant: got %0d grant cycles want 0", seen);
    end
    push_exp(4'b0001, 1'b0);
    do_tick(2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; req = '0; hit = '0; sel = 1'b0;
    test_reset();
    test_single_grant();
    test_pool_full_and_hit();
    test_rr_wrap();
    test_tick_while_busy();
    test_lifetime();
    test_cooldown();
    test_reset_in_arb();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
